// File: rtl/branch_flag_unit.sv
// -----------------------------------------------------------------------------
// branch_flag_unit
//   Consumer end of the ALU flag interface. Owns the architectural {N,Z,V}
//   flag register, updates it per EX opcode class, resolves B/BR branches in
//   the ID stage using same-cycle bypassed flags, and issues a registered
//   one-cycle redirect/flush to fetch. Also keeps a saturating count of
//   taken branches.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   stall           freezes flags, FSM, outputs and counter
//   ex_valid        EX-stage instruction valid
//   ex_opcode       EX opcode [15:12], selects which flags are written
//   alu_flags       ALU result flags {N,Z,V}
//   id_valid        ID-stage instruction valid
//   id_is_b         ID holds B (PC-relative, wins over BR)
//   id_is_br        ID holds BR (register target)
//   id_cond         branch condition code
//   id_pc_plus2     PC+2 of the ID instruction
//   id_imm          signed halfword offset for B
//   id_rs_data      target register value for BR
//   flags_q         architectural {N,Z,V}
//   redirect_valid  fetch loads redirect_pc (registered)
//   redirect_pc     latched branch target
//   flush_if        squash the IF/ID instruction (registered)
//   taken_count     saturating taken-branch counter
// -----------------------------------------------------------------------------
module branch_flag_unit #(
    parameter int WIDTH = 16,
    parameter int IMM_W = 9,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             ex_valid,
    input  logic [3:0]       ex_opcode,
    input  logic [2:0]       alu_flags,
    input  logic             id_valid,
    input  logic             id_is_b,
    input  logic             id_is_br,
    input  logic [2:0]       id_cond,
    input  logic [WIDTH-1:0] id_pc_plus2,
    input  logic [IMM_W-1:0] id_imm,
    input  logic [WIDTH-1:0] id_rs_data,
    output logic [2:0]       flags_q,
    output logic             redirect_valid,
    output logic [WIDTH-1:0] redirect_pc,
    output logic             flush_if,
    output logic [CNT_W-1:0] taken_count
);

    // Opcode classes that touch the flags.
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;

    // Flag bit positions inside {N,Z,V}.
    localparam int FN = 2;
    localparam int FZ = 1;
    localparam int FV = 0;

    // Condition codes.
    localparam logic [2:0] CC_NE = 3'b000;
    localparam logic [2:0] CC_EQ = 3'b001;
    localparam logic [2:0] CC_GT = 3'b010;
    localparam logic [2:0] CC_LT = 3'b011;
    localparam logic [2:0] CC_GE = 3'b100;
    localparam logic [2:0] CC_LE = 3'b101;
    localparam logic [2:0] CC_OV = 3'b110;

    typedef enum logic {IDLE, REDIRECT} state_t;

    // Resolved branch as seen by the FSM.
    typedef struct packed {
        logic             take;
        logic [WIDTH-1:0] target;
    } br_resp_t;

    state_t           state;
    logic [2:0]       wr_mask;
    logic [2:0]       eff_flags;
    logic             cond_true;
    logic [WIDTH-1:0] imm_sext;
    logic [WIDTH-1:0] b_target;
    br_resp_t         br;

    // Which flag bits EX writes this cycle. Gated by stall so a stalled
    // EX neither updates flags_q nor feeds the bypass.
    always_comb begin
        wr_mask = 3'b000;
        if (ex_valid && !stall) begin
            case (ex_opcode)
                OP_ADD, OP_SUB:                 wr_mask = 3'b111;
                OP_XOR, OP_SLL, OP_SRA, OP_ROR: wr_mask = 3'b010;
                default:                        wr_mask = 3'b000;
            endcase
        end
    end

    // Per-bit bypass: a bit being written by EX this cycle is taken from
    // the ALU, otherwise from the architectural register. The same value is
    // the next-state of flags_q, so write and bypass can never disagree.
    for (genvar i = 0; i < 3; i++) begin : g_flag
        assign eff_flags[i] = wr_mask[i] ? alu_flags[i] : flags_q[i];
    end

    always_comb begin
        cond_true = 1'b1;
        case (id_cond)
            CC_NE:   cond_true = !eff_flags[FZ];
            CC_EQ:   cond_true = eff_flags[FZ];
            CC_GT:   cond_true = !eff_flags[FZ] && !eff_flags[FN];
            CC_LT:   cond_true = eff_flags[FN];
            // Z | (~Z & ~N) reduces to Z | ~N.
            CC_GE:   cond_true = eff_flags[FZ] || !eff_flags[FN];
            CC_LE:   cond_true = eff_flags[FN] || eff_flags[FZ];
            CC_OV:   cond_true = eff_flags[FV];
            default: cond_true = 1'b1;
        endcase
    end

    // B target wraps modulo 2^WIDTH; no overflow reporting.
    assign imm_sext = {{(WIDTH-IMM_W){id_imm[IMM_W-1]}}, id_imm};
    assign b_target = id_pc_plus2 + (imm_sext << 1);

    always_comb begin
        br.take   = id_valid && (id_is_b || id_is_br) && cond_true &&
                    (state == IDLE) && !stall;
        br.target = id_is_b ? b_target : id_rs_data;
    end

    // REDIRECT lasts one non-stalled cycle; ID is wrong-path during it,
    // which the state==IDLE term in take already enforces.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            flags_q        <= 3'b000;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush_if       <= 1'b0;
            taken_count    <= '0;
        end else begin
            flags_q <= eff_flags;
            if (!stall) begin
                case (state)
                    IDLE: begin
                        if (br.take) begin
                            state          <= REDIRECT;
                            redirect_valid <= 1'b1;
                            flush_if       <= 1'b1;
                            redirect_pc    <= br.target;
                            if (taken_count != {CNT_W{1'b1}})
                                taken_count <= taken_count + 1'b1;
                        end
                    end
                    REDIRECT: begin
                        state          <= IDLE;
                        redirect_valid <= 1'b0;
                        flush_if       <= 1'b0;
                    end
                    default: begin
                        state          <= IDLE;
                        redirect_valid <= 1'b0;
                        flush_if       <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_branch_flag_unit.sv
module tb_branch_flag_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        ex_valid;
    logic [3:0]  ex_opcode;
    logic [2:0]  alu_flags;
    logic        id_valid;
    logic        id_is_b;
    logic        id_is_br;
    logic [2:0]  id_cond;
    logic [15:0] id_pc_plus2;
    logic [8:0]  id_imm;
    logic [15:0] id_rs_data;
    logic [2:0]  flags_q;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        flush_if;
    logic [15:0] taken_count;

    // Narrow-counter copy driven identically, used to reach saturation.
    logic [2:0]  s_flags_q;
    logic        s_redirect_valid;
    logic [15:0] s_redirect_pc;
    logic        s_flush_if;
    logic [3:0]  s_taken_count;

    branch_flag_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid),
        .ex_opcode(ex_opcode), .alu_flags(alu_flags), .id_valid(id_valid),
        .id_is_b(id_is_b), .id_is_br(id_is_br), .id_cond(id_cond),
        .id_pc_plus2(id_pc_plus2), .id_imm(id_imm), .id_rs_data(id_rs_data),
        .flags_q(flags_q), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .flush_if(flush_if),
        .taken_count(taken_count)
    );

    branch_flag_unit #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid),
        .ex_opcode(ex_opcode), .alu_flags(alu_flags), .id_valid(id_valid),
        .id_is_b(id_is_b), .id_is_br(id_is_br), .id_cond(id_cond),
        .id_pc_plus2(id_pc_plus2), .id_imm(id_imm), .id_rs_data(id_rs_data),
        .flags_q(s_flags_q), .redirect_valid(s_redirect_valid),
        .redirect_pc(s_redirect_pc), .flush_if(s_flush_if),
        .taken_count(s_taken_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] cnt;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_cnt = 16'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected redirect: appears one clock after the upcoming edge's take.
    task automatic push_take(input logic [15:0] pc);
        exp_t e;
        if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        e.pc  = pc;
        e.cnt = exp_cnt;
        e.cyc = cyc + 1;
        q.push_back(e);
    endtask

    // Monitor: one event per rising redirect_valid.
    initial begin : monitor
        logic rv_prev;
        exp_t e;
        rv_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (redirect_valid === 1'b1 && rv_prev !== 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_redirect: got pc %0h at cycle %0d expected none",
                             redirect_pc, cyc);
                end else begin
                    e = q.pop_front();
                    chk("redirect_pc", redirect_pc, e.pc);
                    chk("redirect_flush", flush_if, 1'b1);
                    chk("redirect_count", taken_count, e.cnt);
                    chk("redirect_latency", cyc, e.cyc);
                end
            end
            rv_prev = redirect_valid;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        ex_valid = 1'b0; ex_opcode = 4'h8; alu_flags = 3'b000;
        id_valid = 1'b0; id_is_b = 1'b0; id_is_br = 1'b0; id_cond = 3'b000;
        id_pc_plus2 = 16'h0; id_imm = 9'h0; id_rs_data = 16'h0;
    endtask

    task automatic drive_b(input logic [2:0] c, input logic [15:0] pc2,
                           input logic [8:0] imm);
        id_valid = 1'b1; id_is_b = 1'b1; id_is_br = 1'b0;
        id_cond = c; id_pc_plus2 = pc2; id_imm = imm;
    endtask

    task automatic drive_br(input logic [2:0] c, input logic [15:0] rs);
        id_valid = 1'b1; id_is_b = 1'b0; id_is_br = 1'b1;
        id_cond = c; id_rs_data = rs;
    endtask

    task automatic drive_ex(input logic [3:0] op, input logic [2:0] f);
        ex_valid = 1'b1; ex_opcode = op; alu_flags = f;
    endtask

    // bit c set => condition c true for flags {N,Z,V} = 100
    logic [7:0] cond_tbl = 8'b1010_1001;

    initial begin
        idle_in();
        rst = 1'b1; stall = 1'b1;
        step(); step();
        // 1: reset with stall asserted
        chk("rst_flags", flags_q, 3'b000);
        chk("rst_rv", redirect_valid, 1'b0);
        chk("rst_pc", redirect_pc, 16'h0);
        chk("rst_flush", flush_if, 1'b0);
        chk("rst_count", taken_count, 16'h0);
        rst = 1'b0; stall = 1'b0;
        step();

        // 2: ADD writes all flags, then B on OV with negative offset
        drive_ex(4'b0000, 3'b011);
        step();
        chk("add_flags", flags_q, 3'b011);
        idle_in();
        drive_b(3'b110, 16'h0010, 9'h1FE);
        push_take(16'h000C);
        step();
        idle_in();
        step();
        chk("redirect_one_cycle", redirect_valid, 1'b0);

        // 3: SUB sets 100, then XOR bypasses Z into an EQ branch
        drive_ex(4'b0001, 3'b100);
        step();
        chk("sub_flags", flags_q, 3'b100);
        drive_ex(4'b0010, 3'b010);
        drive_b(3'b001, 16'h0100, 9'h004);
        push_take(16'h0108);
        step();
        chk("xor_z_only", flags_q, 3'b110);
        idle_in();
        step();
        // bypassed Z=0 overrides stored Z=1: EQ not taken
        drive_ex(4'b0100, 3'b000);
        drive_b(3'b001, 16'h0200, 9'h010);
        step();
        chk("sll_z_only", flags_q, 3'b100);
        idle_in();
        step();

        // condition table against flags 100
        for (int c = 0; c < 8; c++) begin
            logic [2:0] cc;
            cc = 3'(c);
            drive_br(cc, 16'h1000 + 16'(c));
            if (cond_tbl[c]) push_take(16'h1000 + 16'(c));
            step();
            idle_in();
            step();
        end
        chk("cond_count", taken_count, 16'd6);

        // 4: non-writing opcodes; OV branch not taken
        drive_ex(4'b0011, 3'b111);
        step();
        chk("red_noflags", flags_q, 3'b100);
        drive_ex(4'b0111, 3'b111);
        step();
        chk("paddsb_noflags", flags_q, 3'b100);
        drive_ex(4'b1010, 3'b111);
        drive_br(3'b110, 16'h4444);
        step();
        chk("op1xxx_noflags", flags_q, 3'b100);
        chk("ov_not_taken", redirect_valid, 1'b0);
        idle_in();
        step();

        // 5: stalled BR, and an ADD that must not land during stall
        stall = 1'b1;
        drive_br(3'b111, 16'hFFFE);
        drive_ex(4'b0000, 3'b011);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_no_rv", redirect_valid, 1'b0);
        end
        chk("stall_flags", flags_q, 3'b100);
        chk("stall_count", taken_count, 16'd6);
        stall = 1'b0;
        ex_valid = 1'b0;
        push_take(16'hFFFE);
        step();
        // REDIRECT held while stalled, back-to-back branch ignored
        stall = 1'b1;
        drive_br(3'b111, 16'h1234);
        step();
        step();
        chk("hold_rv", redirect_valid, 1'b1);
        chk("hold_flush", flush_if, 1'b1);
        chk("hold_pc", redirect_pc, 16'hFFFE);
        stall = 1'b0;
        step();
        chk("b2b_ignored", redirect_valid, 1'b0);
        chk("b2b_count", taken_count, 16'd7);
        idle_in();
        step();

        // 6: wrap-around B target, then reset during REDIRECT
        drive_b(3'b111, 16'hFFFE, 9'h002);
        push_take(16'h0002);
        step();
        idle_in();
        rst = 1'b1;
        step();
        exp_cnt = 16'd0;
        chk("rst_redirect_rv", redirect_valid, 1'b0);
        chk("rst_redirect_flush", flush_if, 1'b0);
        chk("rst_redirect_count", taken_count, 16'd0);
        rst = 1'b0;
        step();

        // saturation on the narrow counter
        for (int i = 0; i < 17; i++) begin
            drive_br(3'b111, 16'h2000 + 16'(i));
            push_take(16'h2000 + 16'(i));
            step();
            idle_in();
            step();
            if (i == 14) chk("sat_reach_max", s_taken_count, 4'hF);
        end
        chk("sat_hold_max", s_taken_count, 4'hF);
        chk("wide_count", taken_count, 16'd17);

        step(); step();
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
